// File: rtl/mul_sched.sv
// mul_sched: two-requester round-robin scheduler around a 4x4 shift-add multiplier.
module mul_sched (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [3:0] x0,
  input  logic [3:0] b0,
  input  logic       req1,
  input  logic [3:0] x1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       busy,
  output logic [7:0] y,
  output logic       done,
  output logic       done_id
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state, cnt;
  logic [3:0] xr, br;
  logic [7:0] acc, acc_n;
  logic       win, win_n, last_id;
  assign win_n = (req0 && req1) ? ~last_id : req1;
  assign acc_n = acc + (xr[cnt] ? ({4'b0, br} << cnt) : 8'd0);
  assign busy  = state != IDLE;
  assign done  = state == DONE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      xr      <= '0;
      br      <= '0;
      acc     <= '0;
      win     <= 1'b0;
      last_id <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      y       <= '0;
      done_id <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: if (req0 || req1) begin
          state <= RUN;
          win   <= win_n;
          xr    <= win_n ? x1 : x0;
          br    <= win_n ? b1 : b0;
          acc   <= '0;
          cnt   <= '0;
          gnt0  <= ~win_n;
          gnt1  <= win_n;
        end
        RUN: begin
          acc <= acc_n;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            y       <= acc_n;
            done_id <= win;
            state   <= DONE;
          end
        end
        DONE: begin
          last_id <= win;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: directed checks of arbitration, latency, products and reset abort.
module tb_mul_sched;
  logic clk = 0, reset = 1;
  logic req0 = 0, req1 = 0;
  logic [3:0] x0 = 0, b0 = 0, x1 = 0, b1 = 0;
  logic gnt0, gnt1, busy, done, done_id;
  logic [7:0] y;
  int total = 0, bad = 0;
  logic both = 0;
  mul_sched dut (.clk(clk), .reset(reset), .req0(req0), .x0(x0), .b0(b0),
                 .req1(req1), .x1(x1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
                 .busy(busy), .y(y), .done(done), .done_id(done_id));
  always #5 clk = ~clk;
  always @(negedge clk) if (gnt0 && gnt1) both = 1;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Caller sets requests before the capturing edge; returns just after E5.
  task automatic op(input logic id, input logic [7:0] ey, input logic drop, input logic scr);
    @(posedge clk);
    @(negedge clk);
    chk("gnt0", gnt0, {7'd0, ~id});
    chk("gnt1", gnt1, {7'd0, id});
    chk("busy_run", busy, 1);
    if (drop) begin req0 = 0; req1 = 0; end
    if (scr) begin x0 = 15; b0 = 15; x1 = 15; b1 = 15; end
    @(negedge clk);
    chk("gnt_pulse", gnt0 | gnt1, 0);
    repeat (2) @(negedge clk);
    chk("done_early", done, 0);
    @(negedge clk);
    chk("done", done, 1);
    chk("y", y, ey);
    chk("done_id", done_id, {7'd0, id});
    chk("busy_done", busy, 1);
    @(negedge clk);
    chk("done_off", done, 0);
    chk("busy_idle", busy, 0);
    chk("y_hold", y, ey);
  endtask
  initial begin
    logic extra;
    #2;
    chk("rst_y", y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_gnt", gnt0 | gnt1, 0);
    chk("rst_id", done_id, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    req0 = 1; x0 = 13; b0 = 11;
    op(0, 8'd143, 1, 0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    req0 = 1; x0 = 3; b0 = 5; req1 = 1; x1 = 15; b1 = 15;
    op(0, 8'd15, 0, 0);
    op(1, 8'd225, 0, 0);
    op(0, 8'd15, 0, 0);
    op(1, 8'd225, 0, 0);
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("gnt_excl", {7'd0, both}, 0);
    req0 = 1; x0 = 0; b0 = 15;
    op(0, 8'd0, 1, 0);
    req0 = 1; x0 = 15; b0 = 0;
    req1 = 0;
    op(0, 8'd0, 1, 0);
    req0 = 1; x0 = 6; b0 = 7;
    @(posedge clk);
    @(negedge clk);
    chk("p_gnt0", gnt0, 1);
    req0 = 0; req1 = 1; x1 = 15; b1 = 15;
    repeat (2) @(negedge clk);
    req1 = 0;
    repeat (2) @(negedge clk);
    chk("p_done", done, 1);
    chk("p_y", y, 8'd42);
    chk("p_id", done_id, 0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      extra = extra | done | gnt0 | gnt1;
    end
    chk("p_no_extra", {7'd0, extra}, 0);
    req0 = 1; x0 = 9; b0 = 9;
    @(posedge clk);
    @(negedge clk);
    req0 = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_y", y, 0);
    chk("ab_gnt", gnt0 | gnt1, 0);
    chk("ab_id", done_id, 0);
    @(negedge clk);
    reset = 0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      extra = extra | done | busy;
    end
    chk("ab_quiet", {7'd0, extra}, 0);
    req0 = 1; x0 = 2; b0 = 7;
    op(0, 8'd14, 1, 0);
    req0 = 1; x0 = 11; b0 = 6;
    op(0, 8'd66, 1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
